qs_bank_sb: RTL and testbench
=============================

# qs_bank_sb

Bank scoreboard for the quicksort engine. It holds the authoritative `bank_state_t` (status and last-word index `n`) for every memory bank and serves the three bank agents: enqueue, sort and dequeue. Each agent sees the state of its selected bank combinationally and posts updates that commit on the next edge. Every update is checked against the bank lifecycle before it is accepted. The block sits between the agents and replaces any per-agent copies of bank state.

## Interface
- `BANK_N`, default `qs_pkg::BANK_N` (2): number of banks; `bank_id_t` is `$clog2(BANK_N)` bits wide.
- `clk` in, 1: clock.
- `rst` in, 1: synchronous, active-high reset.
- `enq_bank_idx` / `srt_bank_idx` / `deq_bank_idx` in, `bank_id_t`: bank currently addressed by each agent.
- `enq_bank` / `srt_bank` / `deq_bank` out, `bank_state_t`: combinational read of the table entry at that agent's index.
- `enq_bank_upd_vld` / `srt_bank_upd_vld` / `deq_bank_upd_vld` in, 1: update request from each agent.
- `enq_bank_upd` / `srt_bank_upd` / `deq_bank_upd` in, `bank_state_t`: new state for the bank at that agent's index.
- `ready_cnt_r` out, `$clog2(BANK_N+1)`: number of banks in READY.
- `sorted_cnt_r` out, `$clog2(BANK_N+1)`: number of banks in SORTED.
- `err_r` out, 1: sticky flag, set when an update is rejected.
- `err_bank_r` out, `bank_id_t`: bank index of the first rejected update.
- `err_agent_r` out, 2: agent of the first rejected update (0 = enq, 1 = srt, 2 = deq).

## Operation
- Lifecycle: READY -> LOADING -> SORTING -> SORTED -> UNLOADING -> READY.
- Owning agent per status:
  - enq owns READY and LOADING.
  - srt owns SORTING.
  - deq owns SORTED and UNLOADING.
- Legal updates (current -> requested), by owner only:
  - enq: READY->LOADING; LOADING->LOADING; LOADING->SORTING.
  - srt: SORTING->SORTING; SORTING->SORTED.
  - deq: SORTED->UNLOADING; UNLOADING->UNLOADING; UNLOADING->READY.
- A same-status write is legal and may change `n`. The dequeue agent rewrites every UNLOADING cycle.
- Any other request is rejected: the table is unchanged and the error is recorded.
- Error capture:
  - `err_r` is set on a rejected update.
  - `err_bank_r` and `err_agent_r` latch only while `err_r` is 0.
  - When several updates are rejected in the same cycle, the lowest agent number wins.
  - `err_r` is cleared only by `rst`.
- Same-bank conflict: two or more agents update one bank in the same cycle.
  - At most one of them can be the owner. The owner's legal write commits.
  - Every non-owner write in that cycle is rejected.
- Different-bank updates in the same cycle all commit independently.
- Legality is judged against the registered (pre-edge) state.
- Counters are recomputed each cycle from the next-state table and registered. They are never incremented.
- A `bank_idx` at or above `BANK_N` on an asserted update is rejected. On read, the output is all-zero.

## Timing
- Reset values:
  - All entries: status READY, `n` = 0.
  - `ready_cnt_r` = `BANK_N`; `sorted_cnt_r` = 0.
  - `err_r` = 0; `err_bank_r` = 0; `err_agent_r` = 0.
- Read latency is 0: `*_bank` follows `*_bank_idx` and the table registers combinationally.
- Write latency is 1: an update accepted in cycle t is visible on every read port in cycle t+1. There is no bypass.
- `ready_cnt_r` and `sorted_cnt_r` reflect the table at t+1, the same cycle the write becomes visible.
- `err_r` asserts in cycle t+1 after a rejection in cycle t.
- Reset mid-operation returns every bank to READY in the next cycle and discards all pending updates.
- Agents re-synchronise by observing READY. No drain is required.

## Structure
- In `qs_pkg`:
  - `bank_status_t` enum: READY, LOADING, SORTING, SORTED, UNLOADING.
  - `bank_state_t` {status, n}.
  - `bank_id_t` and `BANK_N`.
  - `agent_t` encoding.
  - A pure function `bank_upd_legal(agent_t, bank_status_t cur, bank_status_t nxt)`.
- Sub-module `qs_bank_sb_entry`, one per bank:
  - Holds the state register.
  - Takes three masked update requests.
  - Returns the next state and a per-agent reject vector.
- The top level performs:
  - decode of each agent's index into entry selects;
  - read multiplexers;
  - counter and error registers.

## Test plan
- Reset, then read every bank from all three ports -> READY, `n`=0; `ready_cnt_r`=2, `sorted_cnt_r`=0, `err_r`=0.
- Full lifecycle on bank 1:
  - enq writes LOADING with `n`=5, then SORTING; srt writes SORTED; deq writes UNLOADING for 6 cycles, then READY.
  - Each state is visible one cycle after its write.
  - `sorted_cnt_r` goes 0->1->0.
  - `ready_cnt_r` goes 2->1->2.
  - `err_r` stays 0.
- Illegal write: srt writes SORTED to bank 0 while bank 0 is READY -> bank 0 stays READY; next cycle `err_r`=1, `err_bank_r`=0, `err_agent_r`=1.
- Concurrent, different banks: in one cycle enq sets bank 0 READY->LOADING and deq sets bank 1 SORTED->UNLOADING -> both commit; `ready_cnt_r`=0, `sorted_cnt_r`=0.
- Same-bank conflict: bank 1 is SORTED; deq writes UNLOADING while enq writes LOADING -> bank 1 becomes UNLOADING; `err_agent_r`=0.
- Mid-unload reset: bank 0 UNLOADING with `n`=7, assert `rst` for one cycle -> next cycle all banks READY, `n`=0, `err_r`=0, counters at reset values.

Source files
------------

// File: rtl/qs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qs_pkg
// Brief    : Shared bank-state types and the bank lifecycle legality rule.
// Revision : 1.0 - initial release
// ============================================================================
package qs_pkg;

    localparam int BANK_N    = 2;
    localparam int BANK_ID_W = (BANK_N > 1) ? $clog2(BANK_N) : 1;
    localparam int N_W       = 8;
    localparam int AGENT_N   = 3;

    typedef logic [BANK_ID_W-1:0] bank_id_t;

    typedef enum logic [2:0] {
        READY     = 3'd0,
        LOADING   = 3'd1,
        SORTING   = 3'd2,
        SORTED    = 3'd3,
        UNLOADING = 3'd4
    } bank_status_t;

    typedef struct packed {
        bank_status_t     status;
        logic [N_W-1:0]   n;
    } bank_state_t;

    typedef enum logic [1:0] {
        AGENT_ENQ = 2'd0,
        AGENT_SRT = 2'd1,
        AGENT_DEQ = 2'd2
    } agent_t;

    // Only the owner of the current status may move it, one step or in place.
    function automatic logic bank_upd_legal(agent_t agent, bank_status_t cur, bank_status_t nxt);
        logic ok;
        ok = 1'b0;
        case (agent)
            AGENT_ENQ: ok = ((cur == READY)   && (nxt == LOADING)) ||
                            ((cur == LOADING) && ((nxt == LOADING) || (nxt == SORTING)));
            AGENT_SRT: ok = (cur == SORTING) && ((nxt == SORTING) || (nxt == SORTED));
            AGENT_DEQ: ok = ((cur == SORTED)    && (nxt == UNLOADING)) ||
                            ((cur == UNLOADING) && ((nxt == UNLOADING) || (nxt == READY)));
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qs_bank_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : qs_bank_sb_if
// Brief    : One agent's read/update port onto the bank scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
interface qs_bank_sb_if;
    import qs_pkg::*;

    bank_id_t    bank_idx;
    bank_state_t bank;
    logic        bank_upd_vld;
    bank_state_t bank_upd;

    modport master (
        output bank_idx,
        output bank_upd_vld,
        output bank_upd,
        input  bank
    );

    modport slave (
        input  bank_idx,
        input  bank_upd_vld,
        input  bank_upd,
        output bank
    );

endinterface
`default_nettype wire

// File: rtl/qs_bank_sb_entry.sv
`default_nettype none
// ============================================================================
// Module   : qs_bank_sb_entry
// Brief    : State register of one bank with lifecycle-checked update arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module qs_bank_sb_entry
    import qs_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic        [AGENT_N-1:0]  upd_vld_i,
    input  bank_state_t [AGENT_N-1:0]  upd_i,
    output bank_state_t                state_o,
    output bank_state_t                state_d_o,
    output logic        [AGENT_N-1:0]  rej_o
);

    bank_state_t               state_q;
    bank_state_t               state_d;
    logic        [AGENT_N-1:0] rej_d;

    // Legality implies ownership, so at most one agent can pass the check.
    always_comb begin
        state_d = state_q;
        rej_d   = '0;
        for (int a = 0; a < AGENT_N; a++) begin
            if (upd_vld_i[a]) begin
                if (bank_upd_legal(agent_t'(a[1:0]), state_q.status, upd_i[a].status)) begin
                    state_d = upd_i[a];
                end else begin
                    rej_d[a] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '{status: READY, n: '0};
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o   = state_q;
    assign state_d_o = state_d;
    assign rej_o     = rej_d;

endmodule
`default_nettype wire

// File: rtl/qs_bank_sb.sv
`default_nettype none
// ============================================================================
// Module   : qs_bank_sb
// Brief    : Authoritative bank-state scoreboard shared by enq, srt and deq agents.
// Revision : 1.0 - initial release
// ============================================================================
module qs_bank_sb
    import qs_pkg::*;
#(
    parameter int BANK_N = qs_pkg::BANK_N
) (
    input  logic                           clk,
    input  logic                           rst,
    qs_bank_sb_if.slave                    enq,
    qs_bank_sb_if.slave                    srt,
    qs_bank_sb_if.slave                    deq,
    output logic [$clog2(BANK_N+1)-1:0]    ready_cnt_r,
    output logic [$clog2(BANK_N+1)-1:0]    sorted_cnt_r,
    output logic                           err_r,
    output bank_id_t                       err_bank_r,
    output logic [1:0]                     err_agent_r
);

    localparam int CNT_W = $clog2(BANK_N + 1);

    logic        [AGENT_N-1:0]              upd_vld;
    bank_id_t    [AGENT_N-1:0]              upd_idx;
    bank_state_t [AGENT_N-1:0]              upd_data;
    logic        [AGENT_N-1:0]              idx_oor;
    logic        [BANK_N-1:0][AGENT_N-1:0]  sel;
    logic        [BANK_N-1:0][AGENT_N-1:0]  rej;
    bank_state_t [BANK_N-1:0]               state_q;
    bank_state_t [BANK_N-1:0]               state_d;
    bank_state_t [AGENT_N-1:0]              rd_data;

    logic [AGENT_N-1:0] rej_agent;
    logic               err_hit;
    logic [1:0]         err_agent_d;
    bank_id_t           err_bank_d;
    logic [CNT_W-1:0]   ready_cnt_d;
    logic [CNT_W-1:0]   sorted_cnt_d;

    logic [CNT_W-1:0]   ready_cnt_q;
    logic [CNT_W-1:0]   sorted_cnt_q;
    logic               err_q;
    bank_id_t           err_bank_q;
    logic [1:0]         err_agent_q;

    assign upd_vld  = {deq.bank_upd_vld, srt.bank_upd_vld, enq.bank_upd_vld};
    assign upd_idx  = {deq.bank_idx,     srt.bank_idx,     enq.bank_idx};
    assign upd_data = {deq.bank_upd,     srt.bank_upd,     enq.bank_upd};

    generate
        for (genvar a = 0; a < AGENT_N; a++) begin : g_agent
            assign idx_oor[a] = upd_vld[a] && (int'(upd_idx[a]) >= BANK_N);
        end

        for (genvar b = 0; b < BANK_N; b++) begin : g_bank
            for (genvar a = 0; a < AGENT_N; a++) begin : g_sel
                assign sel[b][a] = upd_vld[a] && (int'(upd_idx[a]) == b);
            end

            qs_bank_sb_entry u_entry (
                .clk       (clk),
                .rst       (rst),
                .upd_vld_i (sel[b]),
                .upd_i     (upd_data),
                .state_o   (state_q[b]),
                .state_d_o (state_d[b]),
                .rej_o     (rej[b])
            );
        end
    endgenerate

    // Out-of-range indices fall through to the all-zero default.
    always_comb begin
        rd_data = '0;
        for (int a = 0; a < AGENT_N; a++) begin
            for (int b = 0; b < BANK_N; b++) begin
                if (int'(upd_idx[a]) == b) begin
                    rd_data[a] = state_q[b];
                end
            end
        end
    end

    assign enq.bank = rd_data[0];
    assign srt.bank = rd_data[1];
    assign deq.bank = rd_data[2];

    always_comb begin
        ready_cnt_d  = '0;
        sorted_cnt_d = '0;
        for (int b = 0; b < BANK_N; b++) begin
            if (state_d[b].status == READY) begin
                ready_cnt_d = ready_cnt_d + CNT_W'(1);
            end
            if (state_d[b].status == SORTED) begin
                sorted_cnt_d = sorted_cnt_d + CNT_W'(1);
            end
        end
    end

    // Descending scan so the lowest-numbered rejecting agent is reported.
    always_comb begin
        rej_agent   = idx_oor;
        err_agent_d = '0;
        err_bank_d  = '0;
        for (int b = 0; b < BANK_N; b++) begin
            rej_agent = rej_agent | rej[b];
        end
        err_hit = |rej_agent;
        for (int a = AGENT_N - 1; a >= 0; a--) begin
            if (rej_agent[a]) begin
                err_agent_d = a[1:0];
                err_bank_d  = upd_idx[a];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_cnt_q  <= CNT_W'(BANK_N);
            sorted_cnt_q <= '0;
            err_q        <= 1'b0;
            err_bank_q   <= '0;
            err_agent_q  <= '0;
        end else begin
            ready_cnt_q  <= ready_cnt_d;
            sorted_cnt_q <= sorted_cnt_d;
            if (err_hit) begin
                err_q <= 1'b1;
            end
            if (err_hit && !err_q) begin
                err_bank_q  <= err_bank_d;
                err_agent_q <= err_agent_d;
            end
        end
    end

    assign ready_cnt_r  = ready_cnt_q;
    assign sorted_cnt_r = sorted_cnt_q;
    assign err_r        = err_q;
    assign err_bank_r   = err_bank_q;
    assign err_agent_r  = err_agent_q;

endmodule
`default_nettype wire

// File: tb/tb_qs_bank_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_qs_bank_sb
// Brief    : Directed and randomized checks of qs_bank_sb against a lifecycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qs_bank_sb;
    import qs_pkg::*;

    localparam int CNT_W = $clog2(BANK_N + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qs_bank_sb_if enq_if ();
    qs_bank_sb_if srt_if ();
    qs_bank_sb_if deq_if ();

    logic [CNT_W-1:0] ready_cnt_r;
    logic [CNT_W-1:0] sorted_cnt_r;
    logic             err_r;
    bank_id_t         err_bank_r;
    logic [1:0]       err_agent_r;

    qs_bank_sb #(.BANK_N(BANK_N)) dut (
        .clk          (clk),
        .rst          (rst),
        .enq          (enq_if),
        .srt          (srt_if),
        .deq          (deq_if),
        .ready_cnt_r  (ready_cnt_r),
        .sorted_cnt_r (sorted_cnt_r),
        .err_r        (err_r),
        .err_bank_r   (err_bank_r),
        .err_agent_r  (err_agent_r)
    );

    int checks = 0;
    int errors = 0;

    // Per-agent stimulus: 0 = enq, 1 = srt, 2 = deq
    bit s_vld [3];
    int s_idx [3];
    int s_st  [3];
    int s_n   [3];

    // Reference model: lifecycle position 0..4 per bank, plus error capture
    int m_st [BANK_N];
    int m_n  [BANK_N];
    bit m_err;
    int m_err_bank;
    int m_err_agent;

    function automatic int owner_of(int st);
        return (st <= 1) ? 0 : ((st == 2) ? 1 : 2);
    endfunction

    function automatic bit m_legal(int ag, int cur, int nxt);
        bit busy;
        busy = (cur == 1) || (cur == 2) || (cur == 4);
        if (owner_of(cur) != ag) return 1'b0;
        return (nxt == (cur + 1) % 5) || (busy && (nxt == cur));
    endfunction

    function automatic int m_count(int st);
        int c = 0;
        for (int b = 0; b < BANK_N; b++) if (m_st[b] == st) c++;
        return c;
    endfunction

    task automatic model_step();
        int nst [BANK_N];
        int nn  [BANK_N];
        bit hit;
        hit = 1'b0;
        if (rst) begin
            for (int b = 0; b < BANK_N; b++) begin
                m_st[b] = 0;
                m_n[b]  = 0;
            end
            m_err = 0; m_err_bank = 0; m_err_agent = 0;
            return;
        end
        nst = m_st;
        nn  = m_n;
        for (int a = 0; a < 3; a++) begin
            if (s_vld[a]) begin
                if (s_idx[a] >= BANK_N || !m_legal(a, m_st[s_idx[a]], s_st[a])) begin
                    if (!m_err && !hit) begin
                        m_err_bank  = s_idx[a];
                        m_err_agent = a;
                    end
                    hit = 1'b1;
                end else begin
                    nst[s_idx[a]] = s_st[a];
                    nn[s_idx[a]]  = s_n[a];
                end
            end
        end
        if (hit) m_err = 1'b1;
        m_st = nst;
        m_n  = nn;
    endtask

    task automatic drive();
        enq_if.bank_upd_vld    = s_vld[0];
        enq_if.bank_idx        = bank_id_t'(s_idx[0]);
        enq_if.bank_upd.status = bank_status_t'(3'(s_st[0]));
        enq_if.bank_upd.n      = N_W'(s_n[0]);
        srt_if.bank_upd_vld    = s_vld[1];
        srt_if.bank_idx        = bank_id_t'(s_idx[1]);
        srt_if.bank_upd.status = bank_status_t'(3'(s_st[1]));
        srt_if.bank_upd.n      = N_W'(s_n[1]);
        deq_if.bank_upd_vld    = s_vld[2];
        deq_if.bank_idx        = bank_id_t'(s_idx[2]);
        deq_if.bank_upd.status = bank_status_t'(3'(s_st[2]));
        deq_if.bank_upd.n      = N_W'(s_n[2]);
    endtask

    task automatic clear_all();
        for (int a = 0; a < 3; a++) begin
            s_vld[a] = 1'b0; s_st[a] = 0; s_n[a] = 0;
        end
        drive();
    endtask

    task automatic set_agent(int a, int idx, int st, int n);
        s_vld[a] = 1'b1; s_idx[a] = idx; s_st[a] = st; s_n[a] = n;
        drive();
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_idx(int b);
        for (int a = 0; a < 3; a++) begin
            s_vld[a] = 1'b0; s_idx[a] = b;
        end
        drive();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_all();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic move_to(int bank, int target, int n);
        // Walk one bank along the lifecycle with owner writes until target.
        for (int st = 1; st <= target; st++) begin
            clear_all();
            set_agent(owner_of(st - 1), bank, st, n);
            step();
        end
        clear_all();
    endtask

    task automatic test_reset();
        do_reset();
        for (int b = 0; b < BANK_N; b++) begin
            read_idx(b);
            checks++;
            if (enq_if.bank !== '0 || srt_if.bank !== '0 || deq_if.bank !== '0) begin
                errors++;
                $display("FAIL reset_bank%0d: enq=%h srt=%h deq=%h required 0", b, enq_if.bank, srt_if.bank, deq_if.bank);
            end
        end
        checks++;
        if (ready_cnt_r !== CNT_W'(BANK_N) || sorted_cnt_r !== '0) begin
            errors++;
            $display("FAIL reset_cnt: ready=%0d sorted=%0d required %0d/0", ready_cnt_r, sorted_cnt_r, BANK_N);
        end
        checks++;
        if (err_r !== 1'b0 || err_bank_r !== '0 || err_agent_r !== 2'd0) begin
            errors++;
            $display("FAIL reset_err: err=%b bank=%0d agent=%0d required 0/0/0", err_r, err_bank_r, err_agent_r);
        end
    endtask

    task automatic test_lifecycle();
        do_reset();
        set_agent(0, 1, LOADING, 5);
        step();
        read_idx(1);
        checks++;
        if (srt_if.bank.status !== LOADING || srt_if.bank.n !== 8'd5 || ready_cnt_r !== CNT_W'(1)) begin
            errors++;
            $display("FAIL life_loading: status=%0d n=%0d ready=%0d required 1/5/1", srt_if.bank.status, srt_if.bank.n, ready_cnt_r);
        end
        set_agent(0, 1, SORTING, 5);
        step();
        read_idx(1);
        checks++;
        if (deq_if.bank.status !== SORTING || deq_if.bank.n !== 8'd5) begin
            errors++;
            $display("FAIL life_sorting: status=%0d n=%0d required 2/5", deq_if.bank.status, deq_if.bank.n);
        end
        clear_all();
        set_agent(1, 1, SORTED, 5);
        step();
        read_idx(1);
        checks++;
        if (enq_if.bank.status !== SORTED || sorted_cnt_r !== CNT_W'(1) || ready_cnt_r !== CNT_W'(1)) begin
            errors++;
            $display("FAIL life_sorted: status=%0d sorted=%0d ready=%0d required 3/1/1", enq_if.bank.status, sorted_cnt_r, ready_cnt_r);
        end
        clear_all();
        for (int k = 0; k < 6; k++) begin
            set_agent(2, 1, UNLOADING, 5 - k);
            #1;
            if (k == 0) begin
                checks++;
                if (deq_if.bank.status !== SORTED) begin
                    errors++;
                    $display("FAIL life_nobypass: status=%0d required 3", deq_if.bank.status);
                end
            end
            step();
            read_idx(1);
            checks++;
            if (deq_if.bank.status !== UNLOADING || int'(deq_if.bank.n) !== 5 - k || sorted_cnt_r !== '0) begin
                errors++;
                $display("FAIL life_unload%0d: status=%0d n=%0d sorted=%0d required 4/%0d/0", k, deq_if.bank.status, deq_if.bank.n, sorted_cnt_r, 5 - k);
            end
        end
        set_agent(2, 1, READY, 0);
        step();
        read_idx(1);
        checks++;
        if (srt_if.bank !== '0 || ready_cnt_r !== CNT_W'(2) || sorted_cnt_r !== '0 || err_r !== 1'b0) begin
            errors++;
            $display("FAIL life_ready: bank=%h ready=%0d sorted=%0d err=%b required 0/2/0/0", srt_if.bank, ready_cnt_r, sorted_cnt_r, err_r);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        set_agent(1, 0, SORTED, 3);
        step();
        read_idx(0);
        checks++;
        if (enq_if.bank.status !== READY || enq_if.bank.n !== 8'd0) begin
            errors++;
            $display("FAIL illegal_state: status=%0d n=%0d required 0/0", enq_if.bank.status, enq_if.bank.n);
        end
        checks++;
        if (err_r !== 1'b1 || err_bank_r !== bank_id_t'(0) || err_agent_r !== 2'd1) begin
            errors++;
            $display("FAIL illegal_err: err=%b bank=%0d agent=%0d required 1/0/1", err_r, err_bank_r, err_agent_r);
        end
    endtask

    task automatic test_concurrent();
        do_reset();
        move_to(1, 3, 5);
        set_agent(0, 0, LOADING, 3);
        set_agent(2, 1, UNLOADING, 5);
        step();
        read_idx(0);
        checks++;
        if (enq_if.bank.status !== LOADING || enq_if.bank.n !== 8'd3) begin
            errors++;
            $display("FAIL conc_bank0: status=%0d n=%0d required 1/3", enq_if.bank.status, enq_if.bank.n);
        end
        read_idx(1);
        checks++;
        if (deq_if.bank.status !== UNLOADING || ready_cnt_r !== '0 || sorted_cnt_r !== '0 || err_r !== 1'b0) begin
            errors++;
            $display("FAIL conc_bank1: status=%0d ready=%0d sorted=%0d err=%b required 4/0/0/0", deq_if.bank.status, ready_cnt_r, sorted_cnt_r, err_r);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        move_to(1, 3, 6);
        set_agent(2, 1, UNLOADING, 4);
        set_agent(0, 1, LOADING, 9);
        step();
        read_idx(1);
        checks++;
        if (srt_if.bank.status !== UNLOADING || srt_if.bank.n !== 8'd4) begin
            errors++;
            $display("FAIL conflict_state: status=%0d n=%0d required 4/4", srt_if.bank.status, srt_if.bank.n);
        end
        checks++;
        if (err_r !== 1'b1 || err_agent_r !== 2'd0 || err_bank_r !== bank_id_t'(1)) begin
            errors++;
            $display("FAIL conflict_err: err=%b agent=%0d bank=%0d required 1/0/1", err_r, err_agent_r, err_bank_r);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        move_to(0, 4, 7);
        set_agent(1, 1, SORTED, 1);
        step();
        read_idx(0);
        checks++;
        if (enq_if.bank.status !== UNLOADING || enq_if.bank.n !== 8'd7 || err_r !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: status=%0d n=%0d err=%b required 4/7/1", enq_if.bank.status, enq_if.bank.n, err_r);
        end
        rst = 1'b1;
        set_agent(2, 0, UNLOADING, 3);
        step();
        rst = 1'b0;
        clear_all();
        for (int b = 0; b < BANK_N; b++) begin
            read_idx(b);
            checks++;
            if (enq_if.bank !== '0 || srt_if.bank !== '0 || deq_if.bank !== '0) begin
                errors++;
                $display("FAIL mid_bank%0d: enq=%h srt=%h deq=%h required 0", b, enq_if.bank, srt_if.bank, deq_if.bank);
            end
        end
        checks++;
        if (err_r !== 1'b0 || ready_cnt_r !== CNT_W'(BANK_N) || sorted_cnt_r !== '0) begin
            errors++;
            $display("FAIL mid_regs: err=%b ready=%0d sorted=%0d required 0/%0d/0", err_r, ready_cnt_r, sorted_cnt_r, BANK_N);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int a = 0; a < 3; a++) begin
                s_vld[a] = 1'($urandom_range(0, 1));
                s_idx[a] = $urandom_range(0, BANK_N - 1);
                case ($urandom_range(0, 3))
                    0:       s_st[a] = $urandom_range(0, 4);
                    1:       s_st[a] = m_st[s_idx[a]];
                    default: s_st[a] = (m_st[s_idx[a]] + 1) % 5;
                endcase
                s_n[a] = $urandom_range(0, 255);
            end
            drive();
            step();
            rst = 1'b0;
            for (int b = 0; b < BANK_N; b++) begin
                read_idx(b);
                checks++;
                if (int'(enq_if.bank.status) !== m_st[b] || int'(enq_if.bank.n) !== m_n[b] ||
                    int'(srt_if.bank.status) !== m_st[b] || int'(srt_if.bank.n) !== m_n[b] ||
                    int'(deq_if.bank.status) !== m_st[b] || int'(deq_if.bank.n) !== m_n[b]) begin
                    errors++;
                    $display("FAIL rand_bank%0d cyc%0d: enq=%h srt=%h deq=%h required status %0d n %0d", b, cyc, enq_if.bank, srt_if.bank, deq_if.bank, m_st[b], m_n[b]);
                end
            end
            checks++;
            if (int'(ready_cnt_r) !== m_count(0) || int'(sorted_cnt_r) !== m_count(3)) begin
                errors++;
                $display("FAIL rand_cnt cyc%0d: ready=%0d sorted=%0d required %0d/%0d", cyc, ready_cnt_r, sorted_cnt_r, m_count(0), m_count(3));
            end
            checks++;
            if (err_r !== m_err || int'(err_bank_r) !== m_err_bank || int'(err_agent_r) !== m_err_agent) begin
                errors++;
                $display("FAIL rand_err cyc%0d: err=%b bank=%0d agent=%0d required %b/%0d/%0d", cyc, err_r, err_bank_r, err_agent_r, m_err, m_err_bank, m_err_agent);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 3; a++) s_idx[a] = 0;
        clear_all();
        test_reset();
        test_lifecycle();
        test_illegal();
        test_concurrent();
        test_conflict();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
